apb_master_bridge: RTL



---
 rtl/apb_master_bridge.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command/response to APB4 requester bridge
//
// Purpose: turns one command at a time into an APB4 SETUP/ACCESS transfer and
// returns the read data and error status on a valid/ready response channel.
// Optional macro APB_TIMEOUT_EN adds an ACCESS-phase watchdog that aborts
// after TIMEOUT_CYCLES wait states.
//
// Ports:
//   PCLK, PRESET            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write/addr/wdata/strb/prot   command fields
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/err/timeout   response fields
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT   APB request
//   PRDATA/PREADY/PSLVERR   APB completion
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  if (TIMEOUT_CYCLES < 1 ||
      (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32)) begin : g_bad_params
    $error("apb_master_bridge: illegal DATA_WIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_complete;
  logic   w_abort;
  logic   w_limit;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  // Held at zero outside ACCESS so every transfer starts its count fresh.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                 r_wait_cnt <= '0;
    else if (r_state != ACCESS) r_wait_cnt <= '0;
    else if (!PREADY)           r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  // True on the wait cycle that would bring the count up to the limit.
  assign w_limit     = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = r_timeout;
`else
  assign w_limit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // PSEL/PENABLE decode straight from the state register so reset clears them
  // without waiting for an edge. cmd_ready is also masked by reset itself.
  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    w_accept   = 1'b0;
    w_complete = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = !PRESET;
        if (cmd_valid && !PRESET) begin
          w_accept = 1'b1;
          w_next   = SETUP;
        end
      end
      SETUP: begin
        PSEL   = 1'b1;
        w_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // Normal completion takes priority over the watchdog.
        if (PREADY) begin
          w_complete = 1'b1;
          w_next     = RESP;
        end else if (w_limit) begin
          w_abort = 1'b1;
          w_next  = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request fields are loaded only on accept, so they hold between transfers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_write ? cmd_wdata : '0;
        PSTRB  <= cmd_write ? cmd_strb : '0;
        PPROT  <= cmd_prot;
      end
      if (w_complete) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_err   <= PSLVERR;
      end else if (w_abort) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)          r_timeout <= 1'b0;
    else if (w_complete) r_timeout <= 1'b0;
    else if (w_abort)    r_timeout <= 1'b1;
  end
`endif

endmodule
